// File: rtl/ps2_kbd_tx_pkg.sv
// Shared types and helpers for the PS/2 keyboard-side transmitter.
// Holds the FSM state enum, frame constants and the frame builder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_HI = 2'd1,
    SHIFT_LO = 2'd2,
    GAP      = 2'd3
  } ps2_tx_state_t;

  localparam int         PS2_FRAME_BITS = 11;
  localparam int         PS2_FIFO_DEPTH = 8;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;

  // Sent LSB first: start(0), data[0..7], odd parity, stop(1).
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Host-side write port, status flags, PS/2 lines and FSM debug state.
// Handshake: data is taken on any clk edge with wr_en=1; a write while full (and no pop) is dropped and sets overflow.
interface ps2_kbd_tx_if;
  import ps2_pkg::*;

  logic [7:0]    data;
  logic          wr_en;
  logic          full;
  logic          overflow;
  logic          busy;
  logic          ps2_clk;
  logic          ps2_data;
  ps2_tx_state_t state;

  modport master (
    output data, wr_en,
    input  full, overflow, busy, ps2_clk, ps2_data, state
  );

  modport slave (
    input  data, wr_en,
    output full, overflow, busy, ps2_clk, ps2_data, state
  );

endinterface

// File: rtl/ps2_tx_fifo.sv
// 8x8 synchronous FIFO feeding the PS/2 serialiser.
// A pop in the same cycle as a write frees the slot, so a write while full is then accepted.
module ps2_tx_fifo
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  logic [7:0] mem [PS2_FIFO_DEPTH];
  logic [2:0] w_ptr;
  logic [2:0] r_ptr;
  logic [3:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 4'd0);
  assign full    = (count == 4'd8);
  assign do_pop  = pop && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rdata   = mem[r_ptr];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      w_ptr    <= 3'd0;
      r_ptr    <= 3'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) w_ptr <= w_ptr + 3'd1;
      if (do_pop)  r_ptr <= r_ptr + 3'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (wr_en && !do_push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[w_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: FIFO-buffered scan codes serialised as 11-bit frames.
// ps2_clk/ps2_data are registered from the current state, so they lag the FSM by one cycle.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV  = 50,
  parameter int IDLE_GAP = 4
) (
  input logic        clk,
  input logic        clr,
  ps2_kbd_tx_if.slave bus
);

  localparam int GAP_CYCLES = IDLE_GAP * 2 * CLK_DIV;
  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int GAP_W      = $clog2(GAP_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t               state_q, state_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic [3:0]                  idx_q, idx_d;
  logic [PS2_FRAME_BITS-1:0]   frame_q, frame_d;
  logic                        pop;
  logic                        ps2_clk_q, ps2_data_q;
  logic [7:0]                  head;
  logic                        empty;

  ps2_tx_fifo u_fifo (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (bus.wr_en),
    .wdata    (bus.data),
    .pop      (pop),
    .rdata    (head),
    .full     (bus.full),
    .empty    (empty),
    .overflow (bus.overflow)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      idx_q   <= 4'd0;
      frame_q <= '1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          frame_d = ps2_frame(head);
          idx_d   = 4'd0;
          div_d   = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT_LO;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (idx_q == IDX_LAST) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SHIFT_HI;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data only updates while in SHIFT_HI, so it is stable whenever the line clock is low.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      ps2_clk_q <= (state_q != SHIFT_LO);
      case (state_q)
        SHIFT_HI: ps2_data_q <= frame_q[idx_q];
        SHIFT_LO: ps2_data_q <= ps2_data_q;
        default:  ps2_data_q <= 1'b1;
      endcase
    end
  end

  assign bus.ps2_clk  = ps2_clk_q;
  assign bus.ps2_data = ps2_data_q;
  assign bus.busy     = (state_q != IDLE) || !empty;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: directed writes, a PS/2 line monitor acting as receiver, expected-frame queue.
module tb_ps2_kbd_tx;
  import ps2_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int IDLE_GAP = 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .IDLE_GAP(IDLE_GAP)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [8:0]  exp_q[$];        // {parity, byte}
  logic [10:0] frame_bits;
  logic [10:0] last_frame;
  int          mon_bits    = 0;
  int          total_falls = 0;
  int          frames_seen = 0;
  int          last_fall   = 0;
  logic        prev_clk    = 1'b1;
  logic        prev_data   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: behaves like a PS/2 host receiver, sampling data on each line-clock fall.
  always @(negedge clk) begin
    logic [8:0] exp_item;
    if (clr) begin
      mon_bits  = 0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (!prev_clk && !bus.ps2_clk)
        check("data_stable_while_clk_low", {31'd0, bus.ps2_data}, {31'd0, prev_data});
      if (prev_clk && !bus.ps2_clk) begin
        if (mon_bits > 0) check("bit_period", cyc - last_fall, 2 * CLK_DIV);
        last_fall = cyc;
        frame_bits[mon_bits] = bus.ps2_data;
        mon_bits++;
        total_falls++;
        if (mon_bits == PS2_FRAME_BITS) begin
          mon_bits   = 0;
          last_frame = frame_bits;
          frames_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %03h expected none", frame_bits);
          end else begin
            exp_item = exp_q.pop_front();
            check("start_bit", {31'd0, frame_bits[0]}, 0);
            check("stop_bit", {31'd0, frame_bits[10]}, 1);
            check("frame_payload", {23'd0, frame_bits[9], frame_bits[8:1]}, {23'd0, exp_item});
          end
        end
      end
      prev_clk  = bus.ps2_clk;
      prev_data = bus.ps2_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b, input logic par, input logic accept);
    bus.data  = b;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (accept) exp_q.push_back({par, b});
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", {31'd0, bus.busy}, 0);
  endtask

  task automatic wait_state_idle(input int max);
    int n = 0;
    while (bus.state != IDLE && n < max) begin
      @(negedge clk);
      n++;
    end
    check("fsm_idle_within_budget", {30'd0, bus.state}, {30'd0, IDLE});
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  // Fill set: byte and hand-counted odd parity bit.
  logic [7:0] fill_b [8] = '{8'h1C, 8'hF0, 8'h32, 8'h5A, 8'h23, 8'h2B, 8'h34, 8'h33};
  logic       fill_p [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int falls_at_clr;
    bus.data  = 8'h00;
    bus.wr_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", {31'd0, bus.ps2_clk}, 1);
    check("rst_ps2_data", {31'd0, bus.ps2_data}, 1);
    check("rst_full", {31'd0, bus.full}, 0);
    check("rst_overflow", {31'd0, bus.overflow}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_state", {30'd0, bus.state}, {30'd0, IDLE});
    clr = 1'b0;
    @(negedge clk);

    // Latency and frame timing for 0x1C
    write_byte(8'h1C, 1'b0, 1'b1);               // edge t sampled it
    check("lat_busy_t", {31'd0, bus.busy}, 1);
    check("lat_data_t", {31'd0, bus.ps2_data}, 1);
    @(negedge clk);                               // after t+1
    check("lat_data_t1", {31'd0, bus.ps2_data}, 1);
    @(negedge clk);                               // after t+2
    check("lat_start_bit_t2", {31'd0, bus.ps2_data}, 0);
    check("lat_clk_high_t2", {31'd0, bus.ps2_clk}, 1);
    repeat (CLK_DIV - 1) @(negedge clk);          // after t+5
    check("lat_clk_still_high", {31'd0, bus.ps2_clk}, 1);
    @(negedge clk);                               // after t+2+CLK_DIV
    check("lat_first_fall", {31'd0, bus.ps2_clk}, 0);
    n = 2 + CLK_DIV;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_cycle", n, 1 + 22 * CLK_DIV + 2 * IDLE_GAP * CLK_DIV);
    check("frame_1c_bits", {21'd0, last_frame}, {21'd0, 11'b100_0011_1000});
    check("frame_1c_falls", total_falls, 11);

    // Parity corner bytes
    write_byte(8'h00, 1'b1, 1'b1);
    write_byte(8'hFF, 1'b1, 1'b1);
    write_byte(8'h01, 1'b0, 1'b1);
    wait_idle(600);

    // Make / break / make stream
    write_byte(8'h1C, 1'b0, 1'b1);
    write_byte(PS2_BREAK, 1'b1, 1'b1);
    write_byte(8'h1C, 1'b0, 1'b1);
    wait_idle(600);
    check("frames_so_far", frames_seen, 7);

    // Overflow: one frame in flight, then 9 writes with no pop
    write_byte(8'h12, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("full_before_write", {31'd0, bus.full}, 0);
      write_byte(fill_b[i], fill_p[i], 1'b1);
    end
    check("full_after_8", {31'd0, bus.full}, 1);
    check("ovf_after_8", {31'd0, bus.overflow}, 0);
    write_byte(8'h77, 1'b1, 1'b0);
    check("ovf_after_9", {31'd0, bus.overflow}, 1);
    check("full_after_9", {31'd0, bus.full}, 1);
    wait_idle(2000);
    check("ovf_sticky", {31'd0, bus.overflow}, 1);
    check("frames_after_ovf", frames_seen, 16);

    // Write while full in the pop cycle
    pulse_clr();
    check("ovf_cleared", {31'd0, bus.overflow}, 0);
    write_byte(8'h12, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) write_byte(fill_b[i], fill_p[i], 1'b1);
    check("full_before_pop", {31'd0, bus.full}, 1);
    wait_state_idle(300);
    check("full_at_pop", {31'd0, bus.full}, 1);
    write_byte(8'h4D, 1'b1, 1'b1);
    check("full_after_pop_write", {31'd0, bus.full}, 1);
    check("no_ovf_pop_write", {31'd0, bus.overflow}, 0);
    wait_idle(2000);
    check("no_ovf_end", {31'd0, bus.overflow}, 0);

    // Reset in the middle of bit 5
    write_byte(8'h55, 1'b1, 1'b0);
    write_byte(8'h66, 1'b1, 1'b0);
    n = 0;
    while (mon_bits != 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit5", mon_bits, 5);
    repeat (CLK_DIV + 1) @(negedge clk);
    falls_at_clr = total_falls;
    #2 clr = 1'b1;
    #1;
    check("clr_ps2_clk", {31'd0, bus.ps2_clk}, 1);
    check("clr_ps2_data", {31'd0, bus.ps2_data}, 1);
    check("clr_busy", {31'd0, bus.busy}, 0);
    check("clr_full", {31'd0, bus.full}, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (300) @(negedge clk);
    check("no_frames_after_clr", total_falls, falls_at_clr);
    check("idle_after_clr", {31'd0, bus.busy}, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
